io_timer_intc: RTL
==================

// Module: io_timer_intc
// PURPOSE
//  Memory-mapped I/O responder on the CPU's io_cs/io_rd/io_wr bus: programmable countdown timer
//  that raises intr toward the MCU and retires it on int_ack. Sits beside I/O memory;
//  its read data is driven onto DY_io. It is the target end of the CPU's I/O and interrupt interface.
// PARAMETERS
//  BASE_ADDR  12'hFF0  12-bit byte base of the 16-byte register window (Addr[11:4] match)
//  PRESCALE   1        sys_clk cycles per timer tick (>=1); 1 = tick every cycle
// PORTS
//  sys_clk  in   1   system clock; all state updates on rising edge
//  sys_rst  in   1   reset, synchronous, active-high
//  io_cs    in   1   I/O chip select from CPU
//  io_rd    in   1   I/O read strobe
//  io_wr    in   1   I/O write strobe
//  Addr     in   32  byte address; only [11:0] decoded, [1:0] ignored
//  D_In     in   32  write data (CPU D_Out)
//  DY_io    out  32  read data; 32'hZZZZ_ZZZZ when not selected for read
//  intr     out  1   interrupt request, level, registered
//  int_ack  in   1   interrupt acknowledge from MCU, single-cycle pulse
// BEHAVIOUR
//  sel = io_cs & (Addr[11:4]==BASE_ADDR[11:4]); reg index = Addr[3:2].
//  Map: 0 CTRL rw {29'b0, IE[2], RELOAD[1], EN[0]}; 1 LOAD rw; 2 COUNT ro; 3 STATUS {31'b0, PEND}, W1C.
//  Read: DY_io = selected reg, combinational, same cycle as sel&io_rd; else high-Z.
//  Write: on edge with sel&io_wr; writes to COUNT ignored. Writing LOAD also sets COUNT=D_In and
//   restarts the prescaler. io_rd&io_wr together: write commits at edge, read shows pre-write value.
//  Reset (sys_rst=1 at edge): CTRL=0, LOAD=0, COUNT=0, PEND=0, prescaler=0, intr=0; DY_io high-Z
//   unless read-selected. Reset overrides any concurrent write/tick/ack.
//  Tick: prescaler counts 0..PRESCALE-1 while EN=1, tick on wrap; EN=0 freezes prescaler and COUNT.
//  On tick: COUNT>1 -> COUNT-1. COUNT==1 or COUNT==0 -> expire:
//   PEND<=1; if RELOAD COUNT<=LOAD else COUNT<=0 and EN<=0.
//   LOAD=0 with RELOAD=1 expires every tick.
//  intr = registered (PEND & IE); rises one cycle after PEND sets. IE=0 masks intr, PEND still sets.
//  Clear PEND: int_ack=1 at edge, or write STATUS with D_In[0]=1. intr low the cycle after clear.
//  Priority at one edge: reset > expire > clear (expire with int_ack/W1C leaves PEND=1).
//  Write to CTRL/LOAD same edge as tick: write wins for the written field; PEND from expire still set.
//  int_ack with PEND=0: no effect. Ack is level-insensitive beyond one cycle (held high clears each cycle).
// STRUCTURE
//  Package io_timer_pkg: register index constants (CTRL/LOAD/COUNT/STATUS), CTRL bit positions,
//   STATUS_PEND bit.
//  Sub-module io_tick_gen (PRESCALE param; en, restart in; tick out) for the prescaler.
//  Top holds decode, register file, COUNT datapath, pending/intr logic, DY_io tristate mux.
// TESTING
//  1 Reset: assert sys_rst 2 cycles mid-count -> all regs 0, intr=0; read CTRL (0xFF0) -> 0.
//  2 One-shot: PRESCALE=1, LOAD=5, CTRL=5 (EN,IE) -> PEND set 5 cycles after EN,
//    intr 1 cycle later, EN reads 0, COUNT=0.
//  3 Auto-reload: LOAD=3, CTRL=7 -> intr every 3 ticks;
//    int_ack pulse drops intr next cycle; COUNT cycles 3,2,1,3.
//  4 Race: int_ack on same edge as expiry -> PEND stays 1, intr stays high; W1C STATUS=1 later clears.
//  5 Mask/decode: CTRL=3 (IE=0) -> PEND sets, intr stays 0; access 0xFE0 -> no write, DY_io high-Z.
//  6 PRESCALE=4, LOAD=2, EN -> expiry after 8 cycles; rewrite LOAD=10 mid-count -> COUNT=10, prescaler restarts.

Source files
------------

// File: rtl/io_timer_pkg.sv
// Shared register map and field positions for the I/O countdown timer.
package io_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_W      = 3;

  localparam int STATUS_PEND = 0;

endpackage

// File: rtl/io_tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; restart rewinds the phase.
module io_tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  // Tick comes from the phase before any restart at this edge, so a
  // LOAD write on a wrap edge still lets that expiry happen.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_timer_intc.sv
// Memory-mapped countdown timer with a pending flag and a registered interrupt line.
module io_timer_intc
  import io_timer_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'hFF0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] Addr,
  input  logic [31:0] D_In,
  output logic [31:0] DY_io,
  output logic        intr,
  input  logic        int_ack
);

  // Bus: no wait states. A read is sel&io_rd and returns data in the same
  // cycle; a write is sel&io_wr and commits at the next rising edge.
  logic       sel;
  logic [1:0] idx;
  logic       wr_ctrl, wr_load, wr_status;
  logic       unused_addr;

  assign sel         = io_cs && (Addr[11:4] == BASE_ADDR[11:4]);
  assign idx         = Addr[3:2];
  assign wr_ctrl     = sel && io_wr && (idx == REG_CTRL);
  assign wr_load     = sel && io_wr && (idx == REG_LOAD);
  assign wr_status   = sel && io_wr && (idx == REG_STATUS);
  assign unused_addr = ^{Addr[31:12], Addr[1:0]};

  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       load_q;
  logic [31:0]       count_q;
  logic              pend_q;
  logic              tick;
  logic              expire;
  logic              clear;

  io_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .en      (ctrl_q[CTRL_EN]),
    .restart (wr_load),
    .tick    (tick)
  );

  // A count of 0 expires like 1 so a zero LOAD with RELOAD fires every tick.
  assign expire = tick && (count_q <= 32'd1);
  assign clear  = int_ack || (wr_status && D_In[STATUS_PEND]);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ctrl_q  <= '0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      pend_q  <= 1'b0;
      intr    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= D_In[CTRL_W-1:0];
      end else if (expire && !ctrl_q[CTRL_RELOAD]) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      if (wr_load) begin
        load_q <= D_In;
      end

      if (wr_load) begin
        count_q <= D_In;
      end else if (expire) begin
        count_q <= ctrl_q[CTRL_RELOAD] ? load_q : 32'd0;
      end else if (tick) begin
        count_q <= count_q - 32'd1;
      end

      // Expiry beats a same-edge acknowledge so no event is lost.
      if (expire) begin
        pend_q <= 1'b1;
      end else if (clear) begin
        pend_q <= 1'b0;
      end

      intr <= pend_q && ctrl_q[CTRL_IE];
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = 32'd0;
    case (idx)
      REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      REG_LOAD:   rdata = load_q;
      REG_COUNT:  rdata = count_q;
      REG_STATUS: rdata = {31'd0, pend_q};
      default:    rdata = 32'd0;
    endcase
  end

  assign DY_io = (sel && io_rd) ? rdata : 32'hzzzz_zzzz;

endmodule
